// File: rtl/hiscore_ram_port.sv
// Shares the game CPU work-RAM port with the hiscore engine: buffers hiscore writes,
// slips them into idle CPU slots or steals a slot when the CPU starves them, and serves uploads.
module hiscore_ram_port #(
  parameter int STARVE_LIMIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] hs_addr,
  input  logic [7:0] hs_data,
  input  logic       hs_write,
  input  logic       ioctl_upload,
  output logic [7:0] hs_rdata,
  input  logic [9:0] cpu_addr,
  input  logic [7:0] cpu_dout,
  input  logic       cpu_we,
  input  logic       cpu_cs,
  output logic [7:0] cpu_din,
  output logic       cpu_wait,
  output logic [9:0] ram_addr,
  output logic [7:0] ram_din,
  output logic       ram_we,
  input  logic [7:0] ram_dout,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT) + 1;

  typedef logic [AW:0]   count_t;
  typedef logic [CW-1:0] starve_t;

  localparam count_t  DEPTH_COUNT = count_t'(FIFO_DEPTH);
  localparam starve_t STEAL_AT    = starve_t'(STARVE_LIMIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    HS_WR,
    STEAL,
    UP_RD
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [1:0]    rst_sync;
  logic          rst_n;
  logic [17:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  count_t        count;
  logic [17:0]   head;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          empty;
  logic          pending;
  starve_t       starve_cnt;
  logic          capture;

  // Assertion is immediate; release is held off two edges so no flop leaves reset mid-cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  assign push_req  = hs_write & ~ioctl_upload;
  assign pop       = (state == HS_WR) || (state == STEAL);
  assign fifo_full = (count == DEPTH_COUNT);
  assign push      = push_req & (~fifo_full | pop);
  assign empty     = (count == '0);
  // A same-cycle push counts as pending so the write slot can open on the very next cycle.
  assign pending   = ~empty | push;
  assign head      = mem[rd_ptr];
  assign cpu_din   = ram_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {hs_addr, hs_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (pop || !pending) begin
      starve_cnt <= '0;
    end else if ((state == IDLE) && cpu_cs) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Buffered writes always win over upload reads, so the buffer drains before any UP_RD.
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE: begin
        if (pending && !cpu_cs) begin
          state_next = HS_WR;
        end else if (pending && (starve_cnt >= STEAL_AT)) begin
          state_next = STEAL;
        end else if (ioctl_upload && !pending && !cpu_cs) begin
          state_next = UP_RD;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ram_addr = cpu_addr;
    ram_din  = cpu_dout;
    ram_we   = cpu_cs & cpu_we;
    cpu_wait = 1'b0;
    case (state)
      HS_WR: begin
        ram_addr = head[17:8];
        ram_din  = head[7:0];
        ram_we   = 1'b1;
      end
      STEAL: begin
        ram_addr = head[17:8];
        ram_din  = head[7:0];
        ram_we   = 1'b1;
        cpu_wait = 1'b1;
      end
      UP_RD: begin
        ram_addr = hs_addr;
        ram_we   = 1'b0;
      end
      default: begin
        ram_we = cpu_cs & cpu_we;
      end
    endcase
  end

  // RAM data arrives the cycle after UP_RD drove the address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      capture  <= 1'b0;
      hs_rdata <= 8'h00;
    end else begin
      capture <= (state == UP_RD);
      if (capture) begin
        hs_rdata <= ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_hiscore_ram_port.sv
// Directed and randomized checks of hiscore_ram_port against a queue-based scoreboard
// and a behavioural work-RAM.
module tb_hiscore_ram_port;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] hs_addr;
  logic [7:0] hs_data;
  logic       hs_write;
  logic       ioctl_upload;
  logic [7:0] hs_rdata;
  logic [9:0] cpu_addr;
  logic [7:0] cpu_dout;
  logic       cpu_we;
  logic       cpu_cs;
  logic [7:0] cpu_din;
  logic       cpu_wait;
  logic [9:0] ram_addr;
  logic [7:0] ram_din;
  logic       ram_we;
  logic [7:0] ram_dout;
  logic       fifo_full;
  logic       overflow;

  logic [7:0]  ram_mem [1024];
  logic [7:0]  exp_ram [1024];
  logic [17:0] exp_q [$];
  logic [9:0]  written [$];
  logic        exp_ovf;
  int          total;
  int          bad;

  hiscore_ram_port #(
    .STARVE_LIMIT(16),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .hs_addr     (hs_addr),
    .hs_data     (hs_data),
    .hs_write    (hs_write),
    .ioctl_upload(ioctl_upload),
    .hs_rdata    (hs_rdata),
    .cpu_addr    (cpu_addr),
    .cpu_dout    (cpu_dout),
    .cpu_we      (cpu_we),
    .cpu_cs      (cpu_cs),
    .cpu_din     (cpu_din),
    .cpu_wait    (cpu_wait),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din),
    .ram_we      (ram_we),
    .ram_dout    (ram_dout),
    .fifo_full   (fifo_full),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Work RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (ram_we) begin
      ram_mem[ram_addr] <= ram_din;
    end
    ram_dout <= ram_mem[ram_addr];
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic w, input logic [9:0] a, input logic [7:0] d,
                                input logic up, input logic cs, input logic we);
    hs_write     = w;
    hs_addr      = a;
    hs_data      = d;
    ioctl_upload = up;
    cpu_cs       = cs;
    cpu_we       = we;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Called at the negedge: scores this cycle's RAM write and push, then moves past the edge.
  task automatic advance();
    logic [17:0] e;
    check_output("fifo_full", fifo_full, exp_q.size() == DEPTH);
    check_output("overflow", overflow, exp_ovf);
    check_output("cpu_din", cpu_din, ram_dout);
    if (ram_we && !(cpu_cs && cpu_we && !cpu_wait)) begin
      if (exp_q.size() == 0) begin
        check_output("spurious_write", ram_we, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check_output("wr_addr", ram_addr, e[17:8]);
        check_output("wr_data", ram_din, e[7:0]);
        exp_ram[e[17:8]] = e[7:0];
        written.push_back(e[17:8]);
      end
    end
    if (hs_write && !ioctl_upload) begin
      if (exp_q.size() < DEPTH) begin
        exp_q.push_back({hs_addr, hs_data});
      end else begin
        exp_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
      step();
    end
    check_output(tag, exp_q.size(), 0);
  endtask

  initial begin
    int   busy_left;
    logic cs_r;
    logic [9:0] a;

    total     = 0;
    bad       = 0;
    exp_ovf   = 1'b0;
    busy_left = 0;
    cs_r      = 1'b0;
    reset_n   = 1'b0;
    cpu_addr  = 10'h000;
    cpu_dout  = 8'h00;
    apply_stimulus(1'b0, 10'h000, 8'h00, 1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check_output("rst_hs_rdata", hs_rdata, 8'h00);
    check_output("rst_cpu_wait", cpu_wait, 1'b0);
    check_output("rst_fifo_full", fifo_full, 1'b0);
    check_output("rst_overflow", overflow, 1'b0);
    check_output("rst_ram_we", ram_we, 1'b0);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Idle CPU: a push appears on the RAM port the next cycle, for one cycle.
    apply_stimulus(1'b1, 10'h123, 8'hA5, 1'b0, 1'b0, 1'b0);
    settle();
    check_output("direct_push_cycle_we", ram_we, 1'b0);
    advance();
    apply_stimulus(1'b0, 10'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    settle();
    check_output("direct_we", ram_we, 1'b1);
    check_output("direct_addr", ram_addr, 10'h123);
    check_output("direct_din", ram_din, 8'hA5);
    advance();
    settle();
    check_output("direct_we_single", ram_we, 1'b0);
    advance();
    repeat (2) step();

    // Busy CPU writing elsewhere: the entry steals exactly cycle 16.
    cpu_addr = 10'h3FF;
    cpu_dout = 8'h77;
    apply_stimulus(1'b1, 10'h2B4, 8'h3C, 1'b0, 1'b1, 1'b1);
    step();
    apply_stimulus(1'b0, 10'h000, 8'h00, 1'b0, 1'b1, 1'b1);
    for (int n = 1; n <= 20; n++) begin
      settle();
      check_output("starve_wait", cpu_wait, n == 16);
      if (n == 16) begin
        check_output("steal_we", ram_we, 1'b1);
        check_output("steal_addr", ram_addr, 10'h2B4);
        check_output("steal_din", ram_din, 8'h3C);
      end
      if (n == 3) begin
        check_output("cpu_pass_we", ram_we, 1'b1);
        check_output("cpu_pass_addr", ram_addr, 10'h3FF);
        check_output("cpu_pass_din", ram_din, 8'h77);
      end
      advance();
    end
    check_output("starve_drained", exp_q.size(), 0);
    apply_stimulus(1'b0, 10'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (2) step();

    // Nine pushes against a busy CPU: eight held, one dropped, then drained in order.
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(1'b1, 10'(10'h300 + i), 8'(8'h10 + i), 1'b0, 1'b1, 1'b0);
      settle();
      if (i == 8) begin
        check_output("full_after_8", fifo_full, 1'b1);
      end
      advance();
    end
    apply_stimulus(1'b0, 10'h000, 8'h00, 1'b0, 1'b1, 1'b0);
    settle();
    check_output("overflow_set", overflow, 1'b1);
    check_output("still_full", fifo_full, 1'b1);
    advance();
    apply_stimulus(1'b0, 10'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    drain("burst_drain", 64);

    // Upload read of 0x040 after seeding it with 0x5C.
    apply_stimulus(1'b1, 10'h040, 8'h5C, 1'b0, 1'b0, 1'b0);
    step();
    apply_stimulus(1'b0, 10'h040, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (4) step();
    apply_stimulus(1'b0, 10'h040, 8'h00, 1'b1, 1'b0, 1'b0);
    settle();
    check_output("upload_hold0", hs_rdata, 8'h00);
    advance();
    settle();
    check_output("upload_addr", ram_addr, 10'h040);
    check_output("upload_we", ram_we, 1'b0);
    check_output("upload_wait", cpu_wait, 1'b0);
    advance();
    settle();
    check_output("upload_hold1", hs_rdata, 8'h00);
    advance();
    settle();
    check_output("upload_data", hs_rdata, 8'h5C);
    advance();
    apply_stimulus(1'b0, 10'h040, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) step();

    // Random traffic with bursty CPU activity.
    for (int c = 0; c < 400; c++) begin
      if (busy_left == 0) begin
        cs_r      = 1'($urandom_range(0, 1));
        busy_left = $urandom_range(1, 24);
      end
      busy_left--;
      apply_stimulus($urandom_range(0, 2) == 0, 10'($urandom), 8'($urandom), 1'b0, cs_r, 1'b0);
      cpu_addr = 10'($urandom);
      cpu_dout = 8'($urandom);
      step();
    end
    apply_stimulus(1'b0, 10'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    drain("random_drain", 100);

    // Upload reads of previously written addresses.
    for (int k = 0; k < 4; k++) begin
      a = written[$urandom_range(0, written.size() - 1)];
      apply_stimulus(1'b0, a, 8'h00, 1'b1, 1'b0, 1'b0);
      repeat (5) step();
      settle();
      check_output("upload_random", hs_rdata, exp_ram[a]);
      advance();
      apply_stimulus(1'b0, a, 8'h00, 1'b0, 1'b0, 1'b0);
      repeat (3) step();
    end

    // Reset with three entries queued discards them.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 10'(10'h111 + i), 8'(8'hC0 + i), 1'b0, 1'b1, 1'b0);
      step();
    end
    apply_stimulus(1'b0, 10'h000, 8'h00, 1'b0, 1'b1, 1'b0);
    reset_n = 1'b0;
    #1;
    check_output("mid_rst_overflow", overflow, 1'b0);
    check_output("mid_rst_fifo_full", fifo_full, 1'b0);
    check_output("mid_rst_hs_rdata", hs_rdata, 8'h00);
    check_output("mid_rst_cpu_wait", cpu_wait, 1'b0);
    check_output("mid_rst_ram_we", ram_we, 1'b0);
    exp_q.delete();
    exp_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    apply_stimulus(1'b0, 10'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 12; n++) begin
      settle();
      check_output("post_rst_no_write", ram_we, 1'b0);
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
